param_cache: RTL
================

Name: param_cache

Overview:
- Parametrised, blocking, direct-mapped data/instruction cache.
- Sits between a pipeline stage (Stage_IF or Stage_MEM) and the Memory block, and generates the stage's stall signal, which feeds icache_stall/dcache_stall.
- Generalises the current single-word stall path: configurable line count and words per line, selectable write-back or write-through policy, and saturating hit/miss counters.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; fixed 32 in this generation.
- LINES, 16, number of lines; power of two, ≥2.
- WORDS, 4, words per line; power of two, ≥1.
- WRITE_BACK, 1, policy select.
  - 1: write-back, write-allocate.
  - 0: write-through, no-write-allocate.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request from the pipeline stage.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bits[1:0] ignored.
- req_wdata  in  DATA_W  write data.
- req_rdata  out  DATA_W  read data; valid when req_valid & ~stall & ~req_we.
- stall  out  1  combinational; pipeline must hold req_* stable while 1.
- mem_req  out  1  memory-side transfer request.
- mem_we  out  1  memory-side write enable.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  a transfer completes at any edge where mem_req & mem_ready.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Address split:
  - offset = addr[2 +: log2(WORDS)]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Per line: valid, dirty (used only when WRITE_BACK=1), tag, WORDS data words.
- hit = valid[index] & (tag match).
- States: IDLE, EVICT, REFILL, WTWRITE, RESP.
- IDLE, req_valid=0: stall=0, no action.
- IDLE, read hit: stall=0, req_rdata = array word, same cycle (0 latency). hit_cnt++.
- IDLE, write hit, WRITE_BACK=1: stall=0; word written and dirty set at the edge. hit_cnt++.
- IDLE, write, WRITE_BACK=0: stall=1, go to WTWRITE. Counts as a hit if hit, else as a miss.
- IDLE, read miss or WB write miss: stall=1, miss_cnt++.
  - Go to EVICT if victim valid & dirty, else to REFILL.
- EVICT:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, k, 2'b00}, mem_wdata=word k.
  - k runs 0..WORDS-1 and advances on mem_ready.
  - After the last word, go to REFILL with k=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, k, 2'b00}.
  - mem_rdata stored into word k on mem_ready.
  - After the last word: valid=1, tag=req tag, dirty=0; go to RESP.
- WTWRITE:
  - mem_req=1, mem_we=1, mem_addr=req_addr word-aligned, mem_wdata=req_wdata.
  - On mem_ready: update the array word if it hit (dirty untouched); go to RESP.
- RESP: one cycle, stall=0, request completes.
  - Reads: req_rdata from array.
  - WB writes: word written and dirty=1 at the edge.
  - WT writes: no further action.
  - Counters not incremented. Go to IDLE.
- Outside EVICT/REFILL/WTWRITE: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Stall duration with mem_ready tied high:
  - clean miss: 1+WORDS cycles
  - dirty miss: 1+2·WORDS cycles
  - WT write: 2 cycles
  - The request completes in the following RESP cycle.
- mem_ready low stretches the current word indefinitely; k holds.
- Counters saturate at 2^CNT_W−1; no wrap-around.
- Reset (any state, including mid-transfer):
  - All valid/dirty cleared, state=IDLE, k=0, counters=0.
  - mem_req=0 from the next cycle; an in-flight memory transfer is abandoned.
  - Array data contents unspecified.
- req_valid dropping during a miss (e.g. pipeline flush): the in-progress line transfer still completes; RESP then performs no write.

Test Plan:
- Defaults, mem_ready=1. After reset, read 0x100 → stall high 5 cycles, mem reads 0x100,0x104,0x108,0x10C; RESP returns mem[0x100]. Then read 0x10C → stall=0, data same cycle. hit_cnt=1, miss_cnt=1.
- Write 0xDEADBEEF to 0x104 (hit, WB) → stall=0, no mem traffic. Then read 0x504 (same index, different tag) → stall 9 cycles. Evict writes 0x100..0x10C including 0xDEADBEEF at 0x104, then refill from 0x500..0x50C.
- WRITE_BACK=0: write 0x55 to 0x200 (miss) → 2-cycle stall, one mem write, no allocation. A following read of 0x200 misses.
- mem_ready toggling 0/1 during REFILL → k advances only on ready cycles; the line matches memory contents exactly.
- Assert rst in the 2nd cycle of REFILL → mem_req=0 next cycle, miss_cnt=0. The retried read misses again.
- Drive 2^CNT_W+3 hits with CNT_W=4 → hit_cnt holds at 15.

Source files
------------

// File: rtl/param_cache_if.sv
// Bundles the pipeline-side request channel and the memory-side transfer
// channel of param_cache. The slave modport is the cache's view; the master
// modport is the environment (pipeline stage plus memory) driving it.
interface param_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Pipeline-side request channel
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_rdata;
  logic              stall;

  // Memory-side transfer channel
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_rdata, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_rdata, stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
endinterface

// File: rtl/param_cache.sv
// Blocking direct-mapped cache between a pipeline stage and memory.
// Read hits and write-back write hits complete in zero extra cycles; misses,
// evictions and write-through writes stall the stage while whole lines (or the
// single write-through word) move over the memory channel one word per
// mem_ready. Hit and miss counters saturate instead of wrapping.
module param_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINES      = 16,
  parameter int WORDS      = 4,
  parameter int WRITE_BACK = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  param_cache_if.slave     bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  // k and offsets keep one bit even for single-word lines, where they stay 0.
  localparam int K_W   = (OFF_W > 0) ? OFF_W : 1;
  localparam int WA_W  = IDX_W + OFF_W;
  localparam bit WB    = (WRITE_BACK != 0);

  typedef enum logic [2:0] {IDLE, EVICT, REFILL, WTWRITE, RESP} state_t;

  // Address field helpers; shifts and masks avoid zero-width slices when WORDS=1.
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[2+OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [K_W-1:0] off_of(input logic [ADDR_W-1:0] a);
    return K_W'((a >> 2) & ADDR_W'(WORDS - 1));
  endfunction

  function automatic logic [WA_W-1:0] word_of(input logic [IDX_W-1:0] idx,
                                              input logic [K_W-1:0]   off);
    return (WA_W'(idx) << OFF_W) | WA_W'(off);
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [K_W-1:0]   k_in);
    return (ADDR_W'(tag) << (2 + OFF_W + IDX_W)) |
           (ADDR_W'(idx) << (2 + OFF_W)) |
           (ADDR_W'(k_in) << 2);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  state_t            state;
  logic [K_W-1:0]    k;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              lat_hit;
  logic              flushed;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];

  logic [IDX_W-1:0]  req_idx, lat_idx;
  logic [TAG_W-1:0]  req_tag, lat_tag;
  logic [K_W-1:0]    req_off, lat_off;
  logic              hit, victim_dirty, k_last;
  logic              idle_wb_write, resp_write, tag_we;
  logic [WA_W-1:0]   rd_word;

  logic              arr_we;
  logic [WA_W-1:0]   arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  assign req_idx = idx_of(bus.req_addr);
  assign req_tag = tag_of(bus.req_addr);
  assign req_off = off_of(bus.req_addr);
  assign lat_idx = idx_of(lat_addr);
  assign lat_tag = tag_of(lat_addr);
  assign lat_off = off_of(lat_addr);

  assign hit          = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign victim_dirty = WB && valid[req_idx] && dirty[req_idx];
  assign k_last       = (k == K_W'(WORDS - 1));

  // Writes that land in the array without a memory transfer.
  assign idle_wb_write = (state == IDLE) && bus.req_valid && bus.req_we && hit && WB;
  // A flushed request leaves the freshly filled line untouched.
  assign resp_write    = (state == RESP) && lat_we && WB && !flushed && bus.req_valid;
  assign tag_we        = (state == REFILL) && bus.mem_ready && k_last;

  // IDLE serves the live request; RESP serves the request latched at the miss.
  assign rd_word       = (state == IDLE) ? word_of(req_idx, req_off) : word_of(lat_idx, lat_off);
  assign bus.req_rdata = data_mem[rd_word];

  // Stall: only read hits and write-back write hits pass through IDLE unstalled.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned and infers a latch.
    bus.stall = 1'b1;
    unique case (state)
      IDLE:    bus.stall = bus.req_valid && !(hit && (!bus.req_we || WB));
      RESP:    bus.stall = 1'b0;
      default: bus.stall = 1'b1;
    endcase
  end

  // Memory channel decoded from the registered state, beat counter and latched request.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      EVICT: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = line_addr(tag_mem[lat_idx], lat_idx, k);
        bus.mem_wdata = data_mem[word_of(lat_idx, k)];
      end
      REFILL: begin
        bus.mem_req   = 1'b1;
        bus.mem_addr  = line_addr(lat_tag, lat_idx, k);
      end
      WTWRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = lat_addr & ~ADDR_W'(3);
        bus.mem_wdata = lat_wdata;
      end
      default: ;
    endcase
  end

  // Single write port into the data array, selected by state.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = '0;
    arr_wdata = '0;
    unique case (state)
      IDLE: if (idle_wb_write) begin
        arr_we    = 1'b1;
        arr_waddr = word_of(req_idx, req_off);
        arr_wdata = bus.req_wdata;
      end
      REFILL: if (bus.mem_ready) begin
        arr_we    = 1'b1;
        arr_waddr = word_of(lat_idx, k);
        arr_wdata = bus.mem_rdata;
      end
      WTWRITE: if (bus.mem_ready && lat_hit) begin
        arr_we    = 1'b1;
        arr_waddr = word_of(lat_idx, lat_off);
        arr_wdata = lat_wdata;
      end
      RESP: if (resp_write) begin
        arr_we    = 1'b1;
        arr_waddr = word_of(lat_idx, lat_off);
        arr_wdata = lat_wdata;
      end
      default: ;
    endcase
  end

  // Data and tag storage; validity lives in the reset-cleared valid bits.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are deliberately not reset so they map onto RAM; a cleared valid bit already hides stale contents.
    if (arr_we && !rst) data_mem[arr_waddr] <= arr_wdata;
    if (tag_we && !rst) tag_mem[lat_idx]    <= lat_tag;
  end

  // Controller FSM with valid/dirty bookkeeping and saturating statistics.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      valid     <= '0;
      dirty     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_hit   <= 1'b0;
      flushed   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          lat_addr  <= bus.req_addr;
          lat_wdata <= bus.req_wdata;
          lat_we    <= bus.req_we;
          lat_hit   <= hit;
          flushed   <= 1'b0;
          k         <= '0;
          if (hit) hit_cnt  <= sat_inc(hit_cnt);
          else     miss_cnt <= sat_inc(miss_cnt);
          if (bus.req_we && !WB)  state <= WTWRITE;
          else if (!hit)          state <= victim_dirty ? EVICT : REFILL;
          else if (bus.req_we)    dirty[req_idx] <= 1'b1;
        end
        EVICT: begin
          if (!bus.req_valid) flushed <= 1'b1;
          if (bus.mem_ready) begin
            if (k_last) begin
              k     <= '0;
              state <= REFILL;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        REFILL: begin
          if (!bus.req_valid) flushed <= 1'b1;
          if (bus.mem_ready) begin
            if (k_last) begin
              valid[lat_idx] <= 1'b1;
              dirty[lat_idx] <= 1'b0;
              k              <= '0;
              state          <= RESP;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        WTWRITE: begin
          if (!bus.req_valid) flushed <= 1'b1;
          if (bus.mem_ready) state <= RESP;
        end
        RESP: begin
          if (resp_write) dirty[lat_idx] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
